// File: rtl/out_serial_port_pkg.sv
// Shared SAP-II serial definitions: 3-bit FSM state encodings and a
// constant clog2 helper, so other SAP-II serial blocks can reuse them.
package out_serial_port_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_PARITY   = 3'd5;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/out_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last one.
// restart forces the count back to 0 (used on every state change and while
// the port has no frame on the line).
module out_bit_timer
    import out_serial_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic CLR_n,
    input  logic restart,
    output logic bit_done
);

    // A one-cycle bit period still gets a 1-bit counter that never leaves 0.
    localparam int TW = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign bit_done = (cnt_q == LAST);

    // Next count: wrap at the end of each bit, clear on restart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_done) cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/out_serial_port.sv
// SAP-II output port with framed serial transmitter.
// Captures WBUS on Lo and sends start / data / [parity] / stop bits,
// handshaking with the consumer via ready and acknowledge.
// Optional even-parity bit: define OUT_SERIAL_PARITY_EN.
module out_serial_port
    import out_serial_port_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] WBUS,
    input  logic             Lo,
    input  logic             ready,
    output logic             serial_out,
    output logic             busy,
    output logic             acknowledge,
    output logic             overrun
);

    localparam int BW = clog2(WIDTH + 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ack_q, ack_d;
    logic             ovr_q, ovr_d;
    logic             bit_done;
    logic             restart;
`ifdef OUT_SERIAL_PARITY_EN
    logic             par_q, par_d;
`endif

    // Timer is held at 0 while no frame is on the line and on every transition.
    assign restart = (state_d != state_q) || (state_q == S_IDLE) || (state_q == S_WAIT_RDY);

    out_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .CLK      (CLK),
        .CLR_n    (CLR_n),
        .restart  (restart),
        .bit_done (bit_done)
    );

    // FSM next-state, shift register, bit counter and status flags.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ack_d     = 1'b0;
        ovr_d     = ovr_q;
`ifdef OUT_SERIAL_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Lo) begin
                    shreg_d = WBUS;
                    ovr_d   = 1'b0;
`ifdef OUT_SERIAL_PARITY_EN
                    par_d   = ^WBUS;
`endif
                    state_d = ready ? S_START : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (ready) state_d = S_START;
            end
            S_START: begin
                if (bit_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_done) begin
                    if (LSB_FIRST != 0) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    else                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
`ifdef OUT_SERIAL_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef OUT_SERIAL_PARITY_EN
            S_PARITY: begin
                if (bit_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        ack_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A load while a frame is pending is dropped and flagged.
        if (Lo && (state_q != S_IDLE)) ovr_d = 1'b1;
        if (state_d != state_q) bit_cnt_d = '0;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ack_q     <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef OUT_SERIAL_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ack_q     <= ack_d;
            ovr_q     <= ovr_d;
`ifdef OUT_SERIAL_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Line level decoded from the current state; idle/mark is 1.
    always_comb begin
        serial_out = 1'b1;
        case (state_q)
            S_START: serial_out = 1'b0;
            S_DATA:  serial_out = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef OUT_SERIAL_PARITY_EN
            S_PARITY: serial_out = par_q;
`endif
            default: serial_out = 1'b1;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign acknowledge = ack_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_out_serial_port.sv
// Directed bench for out_serial_port: two instances (LSB-first and
// MSB-first) share one stimulus stream. Honors OUT_SERIAL_PARITY_EN.
module tb_out_serial_port;

    logic       CLK = 1'b0;
    logic       CLR_n = 1'b0;
    logic       Lo = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] WBUS = 8'h00;
    logic so_l, busy_l, ack_l, ovr_l;
    logic so_m, busy_m, ack_m, ovr_m;

    int tests = 0;
    int fails = 0;

`ifdef OUT_SERIAL_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * 4;

    out_serial_port #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .LSB_FIRST(1)) dut_lsb (
        .CLK(CLK), .CLR_n(CLR_n), .WBUS(WBUS), .Lo(Lo), .ready(ready),
        .serial_out(so_l), .busy(busy_l), .acknowledge(ack_l), .overrun(ovr_l));

    out_serial_port #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .LSB_FIRST(0)) dut_msb (
        .CLK(CLK), .CLR_n(CLR_n), .WBUS(WBUS), .Lo(Lo), .ready(ready),
        .serial_out(so_m), .busy(busy_m), .acknowledge(ack_m), .overrun(ovr_m));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected line level in bit slot 'slot' of a frame carrying d.
    function automatic logic exp_level(input logic [7:0] d, input bit lsb, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return lsb ? d[slot-1] : d[8-slot];
`ifdef OUT_SERIAL_PARITY_EN
        if (slot == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called in cycle 0 after the loading edge; returns in the acknowledge cycle.
    // ovr_at >= 0 injects a rejected Lo (WBUS=3C) in that cycle.
    task automatic check_frame(input logic [7:0] d, input int ovr_at);
        for (int k = 0; k < FL; k++) begin
            chk("so_lsb",  so_l,  exp_level(d, 1'b1, k / 4));
            chk("so_msb",  so_m,  exp_level(d, 1'b0, k / 4));
            chk("busy",    busy_l, 1);
            chk("ack_low", ack_l, 0);
            chk("overrun", ovr_l, (ovr_at >= 0 && k > ovr_at) ? 1 : 0);
            if (k == ovr_at) begin
                Lo   = 1'b1;
                WBUS = 8'h3C;
            end else begin
                Lo = 1'b0;
            end
            step();
        end
        chk("ack_lsb",  ack_l,  1);
        chk("ack_msb",  ack_m,  1);
        chk("busy_ack", busy_l, 0);
        chk("so_ack",   so_l,   1);
        chk("ovr_ack",  ovr_l,  (ovr_at >= 0) ? 1 : 0);
    endtask

    initial begin
        // Reset state, checked both asynchronously and across edges.
        #3;
        chk("rst_so",   so_l,   1);
        chk("rst_busy", busy_l, 0);
        chk("rst_ack",  ack_l,  0);
        chk("rst_ovr",  ovr_l,  0);
        step();
        step();
        chk("rst_so_m",   so_m,   1);
        chk("rst_busy_m", busy_m, 0);
        CLR_n = 1'b1;
        ready = 1'b1;

        // Frame 8'h25 with a rejected mid-frame load of 8'h3C.
        WBUS = 8'h25;
        Lo   = 1'b1;
        step();
        check_frame(8'h25, 10);

        // Load during acknowledge: back-to-back frame, overrun cleared.
        WBUS = 8'h3C;
        Lo   = 1'b1;
        step();
        check_frame(8'h3C, -1);
        Lo = 1'b0;
        step();
        chk("ack_one_cycle", ack_l,  0);
        chk("idle_busy",     busy_l, 0);
        chk("idle_so",       so_l,   1);

        // ready low at load: hold mark level for 10 cycles, then start.
        ready = 1'b0;
        WBUS  = 8'hA5;
        Lo    = 1'b1;
        step();
        Lo = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wait_so",   so_l,   1);
            chk("wait_busy", busy_l, 1);
            if (i == 9) ready = 1'b1;
            step();
        end
        check_frame(8'hA5, -1);
        Lo = 1'b0;
        step();

        // Reset during the 5th data bit, after an overrun.
        WBUS = 8'h25;
        Lo   = 1'b1;
        step();
        for (int k = 0; k < 22; k++) begin
            Lo = (k == 5);
            if (k == 5) WBUS = 8'h3C;
            step();
        end
        chk("pre_rst_so",  so_l,  0);
        chk("pre_rst_ovr", ovr_l, 1);
        #2;
        CLR_n = 1'b0;
        #1;
        chk("midrst_so",   so_l,   1);
        chk("midrst_busy", busy_l, 0);
        chk("midrst_ovr",  ovr_l,  0);
        chk("midrst_so_m", so_m,   1);
        #2;
        CLR_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("post_rst_ack",  ack_l,  0);
            chk("post_rst_busy", busy_l, 0);
            chk("post_rst_so",   so_l,   1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
